// File: rtl/bit_packer_param_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : bit_packer_param_if                                        |
// | Brief    : Handshake bundle for the serial-bit to word packer:        |
// |            bit input stream, flush request/ack, word output stream.   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
interface bit_packer_param_if #(
   parameter int OUT_W = 8
);
   logic                         in_valid;
   logic                         in_bit;
   logic                         in_ready;
   logic                         flush;
   logic                         flush_ack;
   logic                         out_valid;
   logic                         out_ready;
   logic [OUT_W-1:0]             out_word;
   logic [$clog2(OUT_W+1)-1:0]   out_nbits;
   logic                         out_last;

   // Packer side
   modport slave (
      input  in_valid, in_bit, flush, out_ready,
      output in_ready, flush_ack, out_valid, out_word, out_nbits, out_last
   );

   // Bit producer / word consumer side
   modport master (
      output in_valid, in_bit, flush, out_ready,
      input  in_ready, flush_ack, out_valid, out_word, out_nbits, out_last
   );
endinterface
`default_nettype wire

// File: rtl/bit_packer_param.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : bit_packer_param                                           |
// | Brief    : Packs a serial bit stream into OUT_W-bit words, with       |
// |            flush of partial words and a small output word FIFO.       |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module bit_packer_param #(
   parameter int OUT_W      = 8,
   parameter int MSB_FIRST  = 1,
   parameter int FIFO_DEPTH = 2
) (
   input wire                   clk,
   input wire                   rst_n,
   bit_packer_param_if.slave    bus
);

   localparam int c_cnt_w = $clog2(OUT_W);
   localparam int c_nb_w  = $clog2(OUT_W + 1);
   localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_occ_w = $clog2(FIFO_DEPTH + 1);

   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(OUT_W - 1);
   localparam logic [c_nb_w-1:0]  c_nb_full  = c_nb_w'(OUT_W);
   localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(FIFO_DEPTH - 1);
   localparam logic [c_occ_w-1:0] c_occ_full = c_occ_w'(FIFO_DEPTH);

   // Accumulator state
   logic [c_cnt_w-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0]   acc_q, acc_d;

   // Output FIFO state
   logic [OUT_W-1:0]   word_q  [FIFO_DEPTH];
   logic [OUT_W-1:0]   word_d  [FIFO_DEPTH];
   logic [c_nb_w-1:0]  nbits_q [FIFO_DEPTH];
   logic [c_nb_w-1:0]  nbits_d [FIFO_DEPTH];
   logic               last_q  [FIFO_DEPTH];
   logic               last_d  [FIFO_DEPTH];
   logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
   logic [c_occ_w-1:0] occ_q, occ_d;

   // Combinational handshake / datapath
   logic               fifo_empty;
   logic               fifo_full;
   logic               pop;
   logic               can_push;
   logic               in_ready;
   logic               flush_ack;
   logic               in_xfer;
   logic               word_done;
   logic               push;
   logic [c_cnt_w-1:0] pos;
   logic [OUT_W-1:0]   acc_next;
   logic [OUT_W-1:0]   push_word;
   logic [c_nb_w-1:0]  push_nbits;

   function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
      return (p == c_ptr_last) ? '0 : p + 1'b1;
   endfunction

   // Handshakes, bit placement and push decision; a flush never adds a second push
   always_comb begin
      fifo_empty = (occ_q == '0);
      fifo_full  = (occ_q == c_occ_full);
      pop        = !fifo_empty && bus.out_ready;
      // A full FIFO can still take a word if the head leaves this same cycle
      can_push   = rst_n && (!fifo_full || pop);
      in_ready   = rst_n && ((cnt_q != c_cnt_last) || can_push);
      flush_ack  = bus.flush && can_push;
      in_xfer    = bus.in_valid && in_ready;

      pos      = (MSB_FIRST != 0) ? (c_cnt_last - cnt_q) : cnt_q;
      acc_next = acc_q;
      if (in_xfer) begin
         acc_next[pos] = bus.in_bit;
      end

      word_done  = in_xfer && (cnt_q == c_cnt_last);
      // Flush with nothing held (and no new bit) only acknowledges
      push       = word_done || (flush_ack && (in_xfer || (cnt_q != '0)));
      push_word  = acc_next;
      push_nbits = word_done ? c_nb_full : (c_nb_w'(cnt_q) + c_nb_w'(in_xfer));
   end

   // Next-state for accumulator and FIFO storage/pointers
   always_comb begin
      cnt_d    = push ? '0 : (cnt_q + c_cnt_w'(in_xfer));
      acc_d    = push ? '0 : acc_next;
      word_d   = word_q;
      nbits_d  = nbits_q;
      last_d   = last_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) begin
         word_d[wr_ptr_q]  = push_word;
         nbits_d[wr_ptr_q] = push_nbits;
         last_d[wr_ptr_q]  = flush_ack;
         wr_ptr_d          = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   // State registers; reset drops every held bit and buffered word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            word_q[i]  <= '0;
            nbits_q[i] <= '0;
            last_q[i]  <= 1'b0;
         end
      end else begin
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         word_q   <= word_d;
         nbits_q  <= nbits_d;
         last_q   <= last_d;
      end
   end

   // Head entry is presented only while the FIFO holds a word, zero otherwise
   assign bus.in_ready  = in_ready;
   assign bus.flush_ack = flush_ack;
   assign bus.out_valid = !fifo_empty;
   assign bus.out_word  = fifo_empty ? '0   : word_q[rd_ptr_q];
   assign bus.out_nbits = fifo_empty ? '0   : nbits_q[rd_ptr_q];
   assign bus.out_last  = fifo_empty ? 1'b0 : last_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_bit_packer_param.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_bit_packer_param                                        |
// | Brief    : Self-checking bench: MSB-first and LSB-first packers fed   |
// |            the same bit stream, words checked against a scoreboard.   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_bit_packer_param;

   logic clk = 1'b0;
   logic rst_n;
   logic in_valid;
   logic in_bit;
   logic flush;
   logic out_ready;

   // 10 ns clock
   always #5 clk = ~clk;

   bit_packer_param_if #(.OUT_W(8)) bus_m ();
   bit_packer_param_if #(.OUT_W(8)) bus_l ();

   assign bus_m.in_valid  = in_valid;
   assign bus_m.in_bit    = in_bit;
   assign bus_m.flush     = flush;
   assign bus_m.out_ready = out_ready;
   assign bus_l.in_valid  = in_valid;
   assign bus_l.in_bit    = in_bit;
   assign bus_l.flush     = flush;
   assign bus_l.out_ready = out_ready;

   bit_packer_param #(.OUT_W(8), .MSB_FIRST(1), .FIFO_DEPTH(2)) u_msb (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_m)
   );

   bit_packer_param #(.OUT_W(8), .MSB_FIRST(0), .FIFO_DEPTH(2)) u_lsb (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_l)
   );

   typedef struct {
      logic [7:0] w_msb;
      logic [7:0] w_lsb;
      logic [3:0] nbits;
      logic       last;
   } exp_t;

   typedef struct {
      int         len;
      logic [0:7] seq;     // seq[k] is the k-th bit sent
      int         fmode;   // 0 none, 1 flush after the bits, 2 flush with last bit
      logic [7:0] e_msb;
      logic [7:0] e_lsb;
      logic [3:0] e_nb;
      logic       e_last;
   } vec_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every word leaving the packers must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_ready && bus_m.out_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=0x%0h required=no_word at %0t",
                     bus_m.out_word, $time);
         end else begin
            e = sb_q.pop_front();
            chk("word_msb",  32'(bus_m.out_word),  32'(e.w_msb));
            chk("word_lsb",  32'(bus_l.out_word),  32'(e.w_lsb));
            chk("nbits",     32'(bus_m.out_nbits), 32'(e.nbits));
            chk("last",      32'(bus_m.out_last),  32'(e.last));
            chk("lsb_valid", 32'(bus_l.out_valid), 32'd1);
         end
      end
   end

   // Offer one bit (optionally with flush) until accepted; returns flush_ack seen
   task automatic xfer_bit(input logic b, input logic with_flush, output logic got_ack);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_bit   = b;
      flush    = with_flush;
      @(negedge clk);
      while (!bus_m.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
      got_ack = bus_m.flush_ack;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   // Hold flush until acknowledged; returns whether the ack was seen
   task automatic do_flush(output logic got_ack);
      int n;
      n     = 0;
      flush = 1'b1;
      @(negedge clk);
      while (!bus_m.flush_ack && n < 50) begin
         @(negedge clk);
         n++;
      end
      got_ack = bus_m.flush_ack;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Global time limit
   initial begin
      #200000;
      failures++;
      $display("FAIL global_timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "time limit");
   end

   initial begin
      vec_t       tbl[7];
      logic       ack;
      logic [7:0] bp_w[3];
      logic [7:0] bp_l[3];
      logic [7:0] w;
      exp_t       e;

      tbl[0] = '{8, 8'b10110010, 0, 8'hB2, 8'h4D, 4'd8, 1'b0};
      tbl[1] = '{3, 8'b10100000, 1, 8'hA0, 8'h05, 4'd3, 1'b1};
      tbl[2] = '{8, 8'b11111111, 0, 8'hFF, 8'hFF, 4'd8, 1'b0};
      tbl[3] = '{8, 8'b00000001, 0, 8'h01, 8'h80, 4'd8, 1'b0};
      tbl[4] = '{1, 8'b10000000, 1, 8'h80, 8'h01, 4'd1, 1'b1};
      tbl[5] = '{7, 8'b11001100, 1, 8'hCC, 8'h33, 4'd7, 1'b1};
      tbl[6] = '{8, 8'b01010101, 2, 8'h55, 8'hAA, 4'd8, 1'b1};

      // ---- reset values, with inputs actively requesting ----
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_bit    = 1'b1;
      flush     = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",  32'(bus_m.in_ready),  32'd0);
      chk("rst_flush_ack", 32'(bus_m.flush_ack), 32'd0);
      chk("rst_out_valid", 32'(bus_m.out_valid), 32'd0);
      chk("rst_out_word",  32'(bus_m.out_word),  32'd0);
      chk("rst_out_nbits", 32'(bus_m.out_nbits), 32'd0);
      chk("rst_out_last",  32'(bus_m.out_last),  32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready",  32'(bus_m.in_ready),  32'd1);
      chk("post_rst_out_valid", 32'(bus_m.out_valid), 32'd0);
      @(posedge clk);
      #1;

      // ---- table-driven single words, consumer always ready ----
      for (int i = 0; i < 7; i++) begin
         e = '{tbl[i].e_msb, tbl[i].e_lsb, tbl[i].e_nb, tbl[i].e_last};
         for (int k = 0; k < tbl[i].len; k++) begin
            if (k == tbl[i].len - 1 && tbl[i].fmode != 1) sb_q.push_back(e);
            xfer_bit(tbl[i].seq[k], (tbl[i].fmode == 2) && (k == tbl[i].len - 1), ack);
            if (tbl[i].fmode == 2 && k == tbl[i].len - 1)
               chk("flush_ack_with_bit", 32'(ack), 32'd1);
         end
         if (tbl[i].fmode == 1) begin
            sb_q.push_back(e);
            do_flush(ack);
            chk("flush_ack", 32'(ack), 32'd1);
         end
         // word visible exactly one cycle after the completing transfer
         @(negedge clk);
         chk("latency_out_valid", 32'(bus_m.out_valid), 32'd1);
         @(posedge clk);
         #1;
         // flush with an empty accumulator right after the partial-word case
         if (i == 1) begin
            do_flush(ack);
            chk("empty_flush_ack", 32'(ack), 32'd1);
            repeat (3) begin
               @(negedge clk);
               chk("empty_flush_no_word", 32'(bus_m.out_valid), 32'd0);
            end
            @(posedge clk);
            #1;
         end
      end
      wait_drain();

      // ---- back-pressure: 24 bits into a 2-deep FIFO ----
      bp_w[0] = 8'h12; bp_w[1] = 8'h34; bp_w[2] = 8'h56;
      bp_l[0] = 8'h48; bp_l[1] = 8'h2C; bp_l[2] = 8'h6A;
      for (int j = 0; j < 3; j++) sb_q.push_back('{bp_w[j], bp_l[j], 4'd8, 1'b0});
      out_ready = 1'b0;
      for (int j = 0; j < 3; j++) begin
         w = bp_w[j];
         for (int k = 0; k < 8; k++) begin
            if (!(j == 2 && k == 7)) xfer_bit(w[7-k], 1'b0, ack);
         end
      end
      w        = bp_w[2];
      in_valid = 1'b1;
      in_bit   = w[0];
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_in_ready_blocked", 32'(bus_m.in_ready), 32'd0);
         chk("bp_out_valid_held",   32'(bus_m.out_valid), 32'd1);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_same_cycle", 32'(bus_m.in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_drain();

      // ---- reset with a buffered word and a partial word ----
      out_ready = 1'b0;
      for (int k = 0; k < 13; k++) xfer_bit(1'b1, 1'b0, ack);
      @(negedge clk);
      chk("pre_rst_out_valid", 32'(bus_m.out_valid), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", 32'(bus_m.out_valid), 32'd0);
      chk("mid_rst_out_word",  32'(bus_m.out_word),  32'd0);
      chk("mid_rst_out_nbits", 32'(bus_m.out_nbits), 32'd0);
      chk("mid_rst_in_ready",  32'(bus_m.in_ready),  32'd0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("rel_out_valid", 32'(bus_m.out_valid), 32'd0);
      chk("rel_in_ready",  32'(bus_m.in_ready),  32'd1);
      @(posedge clk);
      #1;
      sb_q.push_back('{8'hC5, 8'hA3, 4'd8, 1'b0});
      w = 8'hC5;
      for (int k = 0; k < 8; k++) xfer_bit(w[7-k], 1'b0, ack);
      wait_drain();
      repeat (5) @(posedge clk);

      chk("final_queue_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
